attack_controller: RTL

ATTACK_CONTROLLER -- requirements
Module: attack_controller

---
 rtl/attack_controller.sv | 202 ++++++++++++++++++++
 1 files changed

// File: rtl/attack_controller.sv
// Attack state machine: wind-up/active/recover phases on game ticks,
// one hit per attack, one-deep press queue during recovery.
//
// Ports:
//   clk          system clock (single domain)
//   reset        asynchronous active-low reset
//   tick         one-cycle game-tick enable
//   btn_light    light-attack button level
//   btn_heavy    heavy-attack button level
//   in_hitrange  opponent inside hit range
//   freeze       round over, attacks disabled
//   attack_state 000 idle, 001 light wind-up, 010 light active,
//                011 heavy wind-up, 100 heavy active, 101 recover
//   busy         high whenever attack_state != 000
//   hit_valid    one-cycle landed-hit strobe
//   hit_damage   damage qualified by hit_valid, 0 otherwise
//   hit_count    landed hits since reset, saturating at 255
module attack_controller #(
    parameter int         LIGHT_WINDUP  = 1,
    parameter int         LIGHT_ACTIVE  = 2,
    parameter int         LIGHT_RECOVER = 2,
    parameter int         HEAVY_WINDUP  = 3,
    parameter int         HEAVY_ACTIVE  = 2,
    parameter int         HEAVY_RECOVER = 4,
    parameter logic [3:0] LIGHT_DMG     = 4'd2,
    parameter logic [3:0] HEAVY_DMG     = 4'd5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick,
    input  logic       btn_light,
    input  logic       btn_heavy,
    input  logic       in_hitrange,
    input  logic       freeze,
    output logic [2:0] attack_state,
    output logic       busy,
    output logic       hit_valid,
    output logic [3:0] hit_damage,
    output logic [7:0] hit_count
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'b000,
        S_LWIND = 3'b001,
        S_LACT  = 3'b010,
        S_HWIND = 3'b011,
        S_HACT  = 3'b100,
        S_REC   = 3'b101
    } state_t;

    // Phase counter is loaded with (length - 1) and counts down;
    // the phase ends on the tick that finds it at zero.
    localparam logic [3:0] LW_LD = 4'(LIGHT_WINDUP - 1);
    localparam logic [3:0] LA_LD = 4'(LIGHT_ACTIVE - 1);
    localparam logic [3:0] LR_LD = 4'(LIGHT_RECOVER - 1);
    localparam logic [3:0] HW_LD = 4'(HEAVY_WINDUP - 1);
    localparam logic [3:0] HA_LD = 4'(HEAVY_ACTIVE - 1);
    localparam logic [3:0] HR_LD = 4'(HEAVY_RECOVER - 1);

    state_t     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic       q_valid_q, q_valid_d;
    logic       q_heavy_q, q_heavy_d;
    logic       hit_done_q, hit_done_d;
    logic       prev_light_q, prev_heavy_q;

    logic       press_l, press_h;
    logic       rq_valid, rq_heavy;
    logic       hit_fire;
    logic [3:0] hit_dmg;

    assign press_l = btn_light & ~prev_light_q;
    assign press_h = btn_heavy & ~prev_heavy_q;

    // Queue contents including this tick's press: heavy replaces
    // anything, light never replaces a queued heavy.
    assign rq_heavy = press_h | (q_valid_q & q_heavy_q);
    assign rq_valid = press_h | press_l | q_valid_q;

    assign hit_fire = tick & ~freeze & in_hitrange & ~hit_done_q &
                      ((state_q == S_LACT) | (state_q == S_HACT));
    assign hit_dmg  = (state_q == S_HACT) ? HEAVY_DMG : LIGHT_DMG;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        q_valid_d  = q_valid_q;
        q_heavy_d  = q_heavy_q;
        hit_done_d = hit_done_q | hit_fire;
        if (tick) begin
            if (freeze) begin
                state_d    = S_IDLE;
                cnt_d      = 4'd0;
                q_valid_d  = 1'b0;
                q_heavy_d  = 1'b0;
                hit_done_d = 1'b0;
            end else begin
                unique case (state_q)
                    S_IDLE: begin
                        if (press_h) begin
                            state_d    = S_HWIND;
                            cnt_d      = HW_LD;
                            hit_done_d = 1'b0;
                        end else if (press_l) begin
                            state_d    = S_LWIND;
                            cnt_d      = LW_LD;
                            hit_done_d = 1'b0;
                        end
                    end
                    S_LWIND: begin
                        if (cnt_q == 4'd0) begin
                            state_d = S_LACT;
                            cnt_d   = LA_LD;
                        end else begin
                            cnt_d = cnt_q - 4'd1;
                        end
                    end
                    S_LACT: begin
                        if (cnt_q == 4'd0) begin
                            state_d = S_REC;
                            cnt_d   = LR_LD;
                        end else begin
                            cnt_d = cnt_q - 4'd1;
                        end
                    end
                    S_HWIND: begin
                        if (cnt_q == 4'd0) begin
                            state_d = S_HACT;
                            cnt_d   = HA_LD;
                        end else begin
                            cnt_d = cnt_q - 4'd1;
                        end
                    end
                    S_HACT: begin
                        if (cnt_q == 4'd0) begin
                            state_d = S_REC;
                            cnt_d   = HR_LD;
                        end else begin
                            cnt_d = cnt_q - 4'd1;
                        end
                    end
                    S_REC: begin
                        if (cnt_q != 4'd0) begin
                            cnt_d     = cnt_q - 4'd1;
                            q_valid_d = rq_valid;
                            q_heavy_d = rq_heavy;
                        end else if (rq_valid) begin
                            // chain straight into the queued attack
                            state_d    = rq_heavy ? S_HWIND : S_LWIND;
                            cnt_d      = rq_heavy ? HW_LD : LW_LD;
                            q_valid_d  = 1'b0;
                            q_heavy_d  = 1'b0;
                            hit_done_d = 1'b0;
                        end else begin
                            state_d = S_IDLE;
                            cnt_d   = 4'd0;
                        end
                    end
                    default: begin
                        state_d = S_IDLE;
                        cnt_d   = 4'd0;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            cnt_q        <= 4'd0;
            q_valid_q    <= 1'b0;
            q_heavy_q    <= 1'b0;
            hit_done_q   <= 1'b0;
            // held buttons must not register as presses after reset
            prev_light_q <= 1'b1;
            prev_heavy_q <= 1'b1;
            busy         <= 1'b0;
            hit_valid    <= 1'b0;
            hit_damage   <= 4'd0;
            hit_count    <= 8'd0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            q_valid_q  <= q_valid_d;
            q_heavy_q  <= q_heavy_d;
            hit_done_q <= hit_done_d;
            busy       <= (state_d != S_IDLE);
            hit_valid  <= hit_fire;
            hit_damage <= hit_fire ? hit_dmg : 4'd0;
            if (hit_fire && hit_count != 8'hff)
                hit_count <= hit_count + 8'd1;
            if (tick) begin
                prev_light_q <= btn_light;
                prev_heavy_q <= btn_heavy;
            end
        end
    end

    assign attack_state = state_q;

endmodule
